// File: rtl/fns_pkg.sv
// rtl/fns_pkg.sv - shared constants, state type and weight helpers for the FNS decoder
package fns_pkg;

    localparam int CW_MIN  = 4;
    localparam int CW_MAX  = 64;
    localparam int BPC_MIN = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fns_state_e;

    // W(0)=1, W(1)=1, W(k)=W(k-1)+W(k-2)
    function automatic logic [63:0] fns_weight(input int k);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] t;
        a = 64'd1;
        b = 64'd1;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Sum of W(0..cw-1) equals W(cw+1)-1; return the bit width of that value
    function automatic int fns_dw(input int cw);
        logic [63:0] v;
        int n;
        v = fns_weight(cw + 1) - 64'd1;
        n = 1;
        for (int i = 0; i < 64; i++) begin
            if ((v >> i) != 64'd0) n = i + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/fns_weight_step.sv
// rtl/fns_weight_step.sv - expands a running Fibonacci weight pair into BPC per-bit weights
module fns_weight_step #(
    parameter int BPC = 4,
    parameter int WW  = 20
) (
    input  logic [WW-1:0]          w0,
    input  logic [WW-1:0]          w1,
    output logic [BPC-1:0][WW-1:0] wbit,
    output logic [WW-1:0]          nw0,
    output logic [WW-1:0]          nw1
);

    always_comb begin
        logic [WW-1:0] a;
        logic [WW-1:0] b;
        logic [WW-1:0] t;
        wbit = '0;
        a    = w0;
        b    = w1;
        for (int i = 0; i < BPC; i++) begin
            wbit[i] = a;
            t       = a + b;
            a       = b;
            b       = t;
        end
        nw0 = a;
        nw1 = b;
    end

endmodule

// File: rtl/fns_dec_iter.sv
// rtl/fns_dec_iter.sv - iterative Fibonacci-number-system codeword decoder, BPC bits per cycle
module fns_dec_iter
    import fns_pkg::*;
#(
    parameter int CW  = 28,
    parameter int BPC = 4,
    localparam int DW    = fns_dw(CW),
    localparam int NBEAT = (CW + BPC - 1) / BPC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] code_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] data_out,
    output logic          nc_out
);

    localparam int SW  = NBEAT * BPC;
    localparam int BCW = $clog2(NBEAT + 1);

    if (CW < CW_MIN || CW > CW_MAX || BPC < BPC_MIN || BPC > CW) begin : g_param_check
        $error("fns_dec_iter: CW or BPC outside legal range");
    end

    fns_state_e            state;
    fns_state_e            state_nx;
    logic [SW-1:0]         shreg;
    logic [DW-1:0]         acc;
    logic [DW-1:0]         w0;
    logic [DW-1:0]         w1;
    logic [BCW-1:0]        beat;
    logic                  nc;
    logic [BPC-1:0][DW-1:0] wbit;
    logic [DW-1:0]         nw0;
    logic [DW-1:0]         nw1;
    logic [DW-1:0]         beat_sum;
    logic                  last_beat;

    fns_weight_step #(
        .BPC (BPC),
        .WW  (DW)
    ) u_step (
        .w0   (w0),
        .w1   (w1),
        .wbit (wbit),
        .nw0  (nw0),
        .nw1  (nw1)
    );

    assign last_beat = (beat == BCW'(NBEAT - 1));

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < BPC; i++) begin
            if (shreg[i]) beat_sum = beat_sum + wbit[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nx = ST_BUSY;
            ST_BUSY: if (last_beat) state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    // Padding above CW in the shift register is zero, so the last beat adds nothing extra
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            acc   <= '0;
            w0    <= '0;
            w1    <= '0;
            beat  <= '0;
            nc    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        shreg <= SW'(code_in);
                        acc   <= '0;
                        w0    <= DW'(1);
                        w1    <= DW'(1);
                        beat  <= '0;
                        nc    <= |(code_in[CW-2:0] & code_in[CW-1:1]);
                    end
                end
                ST_BUSY: begin
                    acc   <= acc + beat_sum;
                    shreg <= shreg >> BPC;
                    w0    <= nw0;
                    w1    <= nw1;
                    beat  <= beat + BCW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign data_out  = acc;
    assign nc_out    = nc;

endmodule

// File: doc/fns_dec_iter.md
FNS_DEC_ITER -- requirements
Module: fns_dec_iter

Interface
REQ-001 Parameter CW, default 28: codeword width in bits; legal range 4..64.
REQ-002 Parameter BPC, default 4: code bits consumed per cycle; legal range 1..CW; need not divide CW.
REQ-003 Derived localparam DW = fns_dw(CW): bit width of (sum of W(0..CW-1)); 20 for CW=28.
REQ-004 Derived localparam NBEAT = ceil(CW/BPC): busy cycles per codeword; 7 for CW=28, BPC=4.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  codeword present on code_in.
REQ-008 in_ready  output  1  block can accept a codeword.
REQ-009 code_in  input  CW  FNS codeword; bit k carries weight W(k).
REQ-010 out_valid  output  1  decoded result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 data_out  output  DW  binary value of the accepted codeword.
REQ-013 nc_out  output  1  non-canonical flag: the codeword contains two adjacent 1 bits.

Function
REQ-014 Weights: W(0)=1, W(1)=1, W(k)=W(k-1)+W(k-2), so W(2)=2 and W(27)=317811.
REQ-015 data_out = sum over k of code_in[k]*W(k), exact and unsigned; no truncation at any CW.
REQ-016 FSM states: IDLE, BUSY, DONE; the reset state is IDLE.
REQ-017 in_ready = 1 only in IDLE; out_valid = 1 only in DONE; both are driven from registered state only.
REQ-018 IDLE with in_valid=1: capture code_in into a shift register, clear the accumulator, load weight pair (W(0), W(1)), clear beat counter, go to BUSY.
REQ-019 BUSY, each cycle: add the lowest BPC shift-register bits times their current weights to the accumulator; shift right by BPC; advance the weight pair by BPC Fibonacci steps; increment the beat counter.
REQ-020 In the final beat, bits beyond CW are zero and contribute nothing.
REQ-021 After beat NBEAT-1 completes, go to DONE; result latency from the accept edge to out_valid high is exactly NBEAT cycles.
REQ-022 nc_out is computed once from the captured codeword, as the OR over k of code[k]&code[k+1], and is held with data_out.
REQ-023 DONE: data_out and nc_out stay stable while out_valid=1 and out_ready=0, with no limit on stall length.
REQ-024 DONE with out_ready=1: return to IDLE on that edge; in_ready rises the next cycle.
REQ-025 Throughput is one codeword per NBEAT+2 cycles when there is no backpressure.
REQ-026 in_valid while not IDLE: code_in is ignored and there is no error.
REQ-027 Weight generation uses a running Fibonacci pair; no CW-entry weight ROM.

Reset
REQ-028 rst_n low, asserted at any time including mid-BUSY or in DONE: FSM goes to IDLE immediately, the in-flight codeword is discarded, and no out_valid follows for it.
REQ-029 Reset values: in_ready=1 (after rst_n release), out_valid=0, data_out=0, nc_out=0; accumulator, shift register, beat counter and weight pair are all 0.

Structure
REQ-030 Shared package fns_pkg holds: function fns_weight(k), function fns_dw(cw), the FSM state enum type, and the CW/BPC legality limits.
REQ-031 One sub-module, fns_weight_step: combinational; takes a weight pair and BPC; outputs the BPC per-bit weights and the next pair. It is instantiated once.
REQ-032 Elaboration fails for CW or BPC outside the legal ranges.

Verification (CW=28, BPC=4 unless stated)
REQ-033 code_in=0 -> data_out=0, nc_out=0, out_valid at exactly accept+7 cycles.
REQ-034 code_in=28'h5 -> data_out=3, nc_out=0; code_in=28'h3 -> data_out=2, nc_out=1.
REQ-035 code_in=28'h8000000 -> data_out=317811; code_in=28'hFFFFFFF -> data_out=832039, nc_out=1.
REQ-036 out_ready held low 10 cycles in DONE -> data_out/out_valid stable throughout; in_valid pulses in that window are ignored.
REQ-037 rst_n pulsed low during beat 3 of a codeword -> IDLE with all outputs at reset values; the next codeword 28'h5 decodes to 3.
REQ-038 CW=13, BPC=5 (NBEAT=3); 2000 random codewords vs the REQ-015 reference model -> all match; back-to-back acceptance every 5 cycles.
